// File: rtl/axil_simple_bridge_q.sv
// AXI-Lite slave to simple-bus master bridge: buffered AW/W/AR channels, R/W arbitration,
// window/alignment checks and slave timeout, with one simple-bus transaction in flight.
module axil_simple_bridge_q_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         nempty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push     = valid_i && rdy_q;
  assign ready_o  = rdy_q;
  assign head_o   = mem_q[rd_q];
  assign nempty_o = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop_i) cnt_d = cnt_q - 1'b1;
  end

  // ready is registered from the next count, so a pop on a full buffer frees
  // the slot only from the following cycle onward.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CW'(DEPTH));
      if (push)  wr_q <= nxt(wr_q);
      if (pop_i) rd_q <= nxt(rd_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end
endmodule

module axil_simple_bridge_q #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                AW_DEPTH    = 2,
  parameter int                W_DEPTH     = 2,
  parameter int                AR_DEPTH    = 2,
  parameter int                ARB_MODE    = 0,
  parameter logic [ADDR_W-1:0] WIN_LO      = '0,
  parameter logic [ADDR_W-1:0] WIN_HI      = '1,
  parameter int                TIMEOUT_CYC = 256,
  localparam int               STRB_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_awvalid_i,
  output logic              s_awready_o,
  input  logic [ADDR_W-1:0] s_awaddr_i,
  input  logic              s_wvalid_i,
  output logic              s_wready_o,
  input  logic [DATA_W-1:0] s_wdata_i,
  input  logic [STRB_W-1:0] s_wstrb_i,
  output logic              s_bvalid_o,
  input  logic              s_bready_i,
  output logic [1:0]        s_bresp_o,
  input  logic              s_arvalid_i,
  output logic              s_arready_o,
  input  logic [ADDR_W-1:0] s_araddr_i,
  output logic              s_rvalid_o,
  input  logic              s_rready_i,
  output logic [DATA_W-1:0] s_rdata_o,
  output logic [1:0]        s_rresp_o,
  output logic              m_valid_o,
  output logic              m_write_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [STRB_W-1:0] m_wstrb_o,
  input  logic              m_ready_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic              m_rvalid_i,
  output logic              err_pulse_o
);
  localparam int OFS = $clog2(STRB_W);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WREQ, RREQ, RWAIT, BRESP, RRESP} state_e;

  state_e                   state_q;
  logic [TW-1:0]            cnt_q;
  logic                     last_wr_q, err_q;
  logic                     m_valid_q, m_write_q, s_bvalid_q, s_rvalid_q;
  logic [ADDR_W-1:0]        m_addr_q;
  logic [DATA_W-1:0]        m_wdata_q, s_rdata_q;
  logic [STRB_W-1:0]        m_wstrb_q;
  logic [1:0]               s_bresp_q, s_rresp_q;

  logic                     aw_ne, w_ne, ar_ne, pop_wr, pop_rd;
  logic [ADDR_W-1:0]        aw_head, ar_head, g_addr;
  logic [DATA_W+STRB_W-1:0] w_head;
  logic                     wr_cand, pick_rd, pick_wr, tmo;
  logic [1:0]               g_resp;

  axil_simple_bridge_q_fifo #(.W(ADDR_W), .DEPTH(AW_DEPTH)) u_aw (
    .clk_i, .rst_ni, .valid_i(s_awvalid_i), .ready_o(s_awready_o), .data_i(s_awaddr_i),
    .pop_i(pop_wr), .head_o(aw_head), .nempty_o(aw_ne));
  axil_simple_bridge_q_fifo #(.W(DATA_W + STRB_W), .DEPTH(W_DEPTH)) u_w (
    .clk_i, .rst_ni, .valid_i(s_wvalid_i), .ready_o(s_wready_o), .data_i({s_wstrb_i, s_wdata_i}),
    .pop_i(pop_wr), .head_o(w_head), .nempty_o(w_ne));
  axil_simple_bridge_q_fifo #(.W(ADDR_W), .DEPTH(AR_DEPTH)) u_ar (
    .clk_i, .rst_ni, .valid_i(s_arvalid_i), .ready_o(s_arready_o), .data_i(s_araddr_i),
    .pop_i(pop_rd), .head_o(ar_head), .nempty_o(ar_ne));

  // Window test uses a modular offset so a single compare covers both bounds.
  function automatic logic [1:0] addr_resp(input logic [ADDR_W-1:0] a);
    if ({1'b0, a - WIN_LO} > {1'b0, WIN_HI - WIN_LO}) return DECERR;
    if (a[OFS-1:0] != '0) return SLVERR;
    return OKAY;
  endfunction

  assign wr_cand = aw_ne && w_ne;
  assign pick_rd = (state_q == IDLE) && ar_ne && (!wr_cand || ARB_MODE == 1 || last_wr_q);
  assign pick_wr = (state_q == IDLE) && wr_cand && !pick_rd;
  assign g_addr  = pick_rd ? ar_head : aw_head;
  assign g_resp  = addr_resp(g_addr);
  assign tmo     = (TIMEOUT_CYC != 0) && (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    pop_wr = 1'b0;
    pop_rd = 1'b0;
    case (state_q)
      IDLE: begin
        pop_wr = pick_wr && (g_resp != OKAY);
        pop_rd = pick_rd && (g_resp != OKAY);
      end
      WREQ:    pop_wr = m_ready_i || tmo;
      RREQ:    pop_rd = m_ready_i ? m_rvalid_i : tmo;
      RWAIT:   pop_rd = m_rvalid_i || tmo;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_wr_q  <= 1'b1;
      err_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      s_bvalid_q <= 1'b0;
      s_bresp_q  <= OKAY;
      s_rvalid_q <= 1'b0;
      s_rresp_q  <= OKAY;
      s_rdata_q  <= '0;
    end else begin
      err_q <= 1'b0;
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_rd || pick_wr) begin
            last_wr_q <= pick_wr;
            if (g_resp != OKAY) begin
              err_q <= 1'b1;
              if (pick_wr) begin
                s_bvalid_q <= 1'b1;
                s_bresp_q  <= g_resp;
                state_q    <= BRESP;
              end else begin
                s_rvalid_q <= 1'b1;
                s_rresp_q  <= g_resp;
                s_rdata_q  <= '0;
                state_q    <= RRESP;
              end
            end else begin
              m_valid_q <= 1'b1;
              m_write_q <= pick_wr;
              m_addr_q  <= g_addr;
              m_wdata_q <= pick_wr ? w_head[DATA_W-1:0] : '0;
              m_wstrb_q <= pick_wr ? w_head[DATA_W+STRB_W-1:DATA_W] : '0;
              state_q   <= pick_wr ? WREQ : RREQ;
            end
          end
        end
        WREQ: begin
          if (m_ready_i || tmo) begin
            m_valid_q  <= 1'b0;
            s_bvalid_q <= 1'b1;
            s_bresp_q  <= m_ready_i ? OKAY : SLVERR;
            err_q      <= !m_ready_i;
            cnt_q      <= '0;
            state_q    <= BRESP;
          end
        end
        RREQ: begin
          if (m_ready_i) begin
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
            if (m_rvalid_i) begin
              s_rvalid_q <= 1'b1;
              s_rresp_q  <= OKAY;
              s_rdata_q  <= m_rdata_i;
              state_q    <= RRESP;
            end else begin
              state_q <= RWAIT;
            end
          end else if (tmo) begin
            m_valid_q  <= 1'b0;
            s_rvalid_q <= 1'b1;
            s_rresp_q  <= SLVERR;
            s_rdata_q  <= '0;
            err_q      <= 1'b1;
            cnt_q      <= '0;
            state_q    <= RRESP;
          end
        end
        RWAIT: begin
          if (m_rvalid_i || tmo) begin
            s_rvalid_q <= 1'b1;
            s_rresp_q  <= m_rvalid_i ? OKAY : SLVERR;
            s_rdata_q  <= m_rvalid_i ? m_rdata_i : '0;
            err_q      <= !m_rvalid_i;
            cnt_q      <= '0;
            state_q    <= RRESP;
          end
        end
        BRESP: begin
          cnt_q <= '0;
          if (s_bready_i) begin
            s_bvalid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        RRESP: begin
          cnt_q <= '0;
          if (s_rready_i) begin
            s_rvalid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_write_o   = m_write_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_wstrb_o   = m_wstrb_q;
  assign s_bvalid_o  = s_bvalid_q;
  assign s_bresp_o   = s_bresp_q;
  assign s_rvalid_o  = s_rvalid_q;
  assign s_rresp_o   = s_rresp_q;
  assign s_rdata_o   = s_rdata_q;
  assign err_pulse_o = err_q;
endmodule
